csela64_stream: RTL and testbench



---
 rtl/csela64_stream.sv | 155 +++++++++++++++
 tb/tb_csela64_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csela64_stream.sv
// csela64_stream
//   Streaming wrapper around a 64-bit carry-select adder. Operand pairs are
//   buffered in a DEPTH-entry FIFO. The FIFO head feeds the adder
//   combinationally, and the result is captured in one registered
//   valid/ready output stage, which has no skid buffer.
//
// Optional feature: define ADDER_OVF_FLAG_EN to add the registered signed
//   overflow output out_ovf.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of FIFO and output stage (data kept)
//   in_valid/in_ready operand handshake; in_ready = !full
//   in_a, in_b        64-bit operands
//   out_valid/out_ready result handshake
//   out_sum, out_cout registered a+b (mod 2^64) and carry-out
//   out_ovf           registered signed overflow (ADDER_OVF_FLAG_EN only)
//   level             FIFO occupancy, 0..DEPTH
module csela64_stream #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_a,
  input  logic [63:0]              in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_sum,
  output logic                     out_cout,
`ifdef ADDER_OVF_FLAG_EN
  output logic                     out_ovf,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int DATA_W = 64;
  localparam int BLK_W  = 16;
  localparam int NBLK   = DATA_W / BLK_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;

  // Carry-select add: every 16-bit block precomputes its sum for both
  // carry-in values, and the incoming block carry selects one of them.
  function automatic logic [DATA_W:0] csel_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic [BLK_W:0]    s0;
    logic [BLK_W:0]    s1;
    logic [DATA_W-1:0] s;
    logic              c;
    s = '0;
    c = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      s0 = {1'b0, a[k*BLK_W +: BLK_W]} + {1'b0, b[k*BLK_W +: BLK_W]};
      s1 = {1'b0, a[k*BLK_W +: BLK_W]} + {1'b0, b[k*BLK_W +: BLK_W]} + {{BLK_W{1'b0}}, 1'b1};
      if (c) begin
        s[k*BLK_W +: BLK_W] = s1[BLK_W-1:0];
        c                   = s1[BLK_W];
      end else begin
        s[k*BLK_W +: BLK_W] = s0[BLK_W-1:0];
        c                   = s0[BLK_W];
      end
    end
    return {c, s};
  endfunction

`ifdef ADDER_OVF_FLAG_EN
  // Two's-complement overflow: operands agree in sign, but the sum does not.
  function automatic logic ovf_flag(input logic signed [DATA_W-1:0] a,
                                    input logic signed [DATA_W-1:0] b,
                                    input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction
`endif

  logic signed [DATA_W-1:0] mem_a_p0 [DEPTH];
  logic signed [DATA_W-1:0] mem_b_p0 [DEPTH];
  logic [AW-1:0]            wr_ptr_p0;
  logic [AW-1:0]            rd_ptr_p0;
  logic                     vld_p1;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic signed [DATA_W-1:0] head_a;
  logic signed [DATA_W-1:0] head_b;
  logic [DATA_W:0]          add_res;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = !full;
  // Full-only acceptance: a pop in the same cycle does not open a slot.
  assign push     = in_valid && !full && !flush;
  assign pop      = !empty && (!vld_p1 || out_ready) && !flush;

  assign head_a    = mem_a_p0[rd_ptr_p0];
  assign head_b    = mem_b_p0[rd_ptr_p0];
  assign add_res   = csel_add(head_a, head_b);
  assign out_valid = vld_p1;

  // ---- stage p0: operand FIFO storage (not reset) ----
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_p0[wr_ptr_p0] <= in_a;
      mem_b_p0[wr_ptr_p0] <= in_b;
    end
  end

  // ---- stage p0: FIFO control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      level     <= '0;
    end else if (flush) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      level     <= '0;
    end else begin
      if (push) wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
      if (pop)  rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---- stage p1: registered adder result ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
`ifdef ADDER_OVF_FLAG_EN
      out_ovf  <= 1'b0;
`endif
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (pop) begin
      vld_p1   <= 1'b1;
      out_sum  <= add_res[DATA_W-1:0];
      out_cout <= add_res[DATA_W];
`ifdef ADDER_OVF_FLAG_EN
      out_ovf  <= ovf_flag(head_a, head_b, add_res[DATA_W-1:0]);
`endif
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csela64_stream.sv
// Testbench for csela64_stream: directed stimulus, a queue-based reference
// model compared on every falling clock edge, and hand-computed literal
// checks at the key points of each scenario.
module tb_csela64_stream;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_a = '0;
  logic [63:0]   in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_sum;
  logic          out_cout;
`ifdef ADDER_OVF_FLAG_EN
  logic          out_ovf;
`endif
  logic [LW-1:0] level;

  int checks = 0;
  int failures = 0;

  csela64_stream #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef ADDER_OVF_FLAG_EN
    .out_ovf   (out_ovf),
`endif
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a queue of pending operand pairs plus the output slot.
  logic [127:0] mq[$];
  logic         m_vld  = 1'b0;
  logic [63:0]  m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_acc;
  logic         m_pop;
  logic [127:0] m_head;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_vld = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_vld = 1'b0;
    end else begin
      m_acc = in_valid && (mq.size() < DEPTH);
      m_pop = (mq.size() > 0) && (!m_vld || out_ready);
      if (m_pop) begin
        m_head = mq.pop_front();
        {m_cout, m_sum} = {1'b0, m_head[127:64]} + {1'b0, m_head[63:0]};
        m_ovf = (m_head[127] == m_head[63]) && (m_sum[63] != m_head[127]);
        m_vld = 1'b1;
      end else if (m_vld && out_ready) begin
        m_vld = 1'b0;
      end
      if (m_acc) mq.push_back({in_a, in_b});
    end
  end

  // Results handed to the consumer, in order.
  logic [64:0] got[$];
  logic [64:0] exp_q[$];

  always @(negedge clk) begin
    chk("out_valid", 65'(out_valid), 65'(m_vld));
    chk("in_ready", 65'(in_ready), 65'(mq.size() < DEPTH));
    chk("level", 65'(level), 65'(mq.size()));
    chk("out_sum", 65'(out_sum), 65'(m_sum));
    chk("out_cout", 65'(out_cout), 65'(m_cout));
`ifdef ADDER_OVF_FLAG_EN
    chk("out_ovf", 65'(out_ovf), 65'(m_ovf));
`endif
    if (out_valid && out_ready) got.push_back({out_cout, out_sum});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b);
    logic took;
    int   n;
    in_a = a; in_b = b; in_valid = 1'b1;
    took = 1'b0; n = 0;
    while (!took && n < 50) begin
      took = in_ready;
      tick();
      n++;
    end
    if (!took) chk("push_timeout", 65'(took), 65'(1));
    in_valid = 1'b0;
    exp_q.push_back({1'b0, a} + {1'b0, b});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((out_valid || level != '0) && n < 100) begin
      tick();
      n++;
    end
    chk("idle_timeout", 65'(out_valid || level != '0), 65'(0));
  endtask

  task automatic single_op(input string tag);
    out_ready = 1'b1;
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    chk({tag, "_lvl1"}, 65'(level), 65'(1));
    chk({tag, "_vld_lo"}, 65'(out_valid), 65'(0));
    tick();
    chk({tag, "_vld_hi"}, 65'(out_valid), 65'(1));
    chk({tag, "_sum"}, 65'(out_sum), 65'(0));
    chk({tag, "_cout"}, 65'(out_cout), 65'(1));
`ifdef ADDER_OVF_FLAG_EN
    chk({tag, "_ovf"}, 65'(out_ovf), 65'(0));
`endif
    wait_idle();
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // Reset state
    tick();
    chk("rst_vld", 65'(out_valid), 65'(0));
    chk("rst_lvl", 65'(level), 65'(0));
    chk("rst_rdy", 65'(in_ready), 65'(1));
    chk("rst_sum", 65'(out_sum), 65'(0));
    chk("rst_cout", 65'(out_cout), 65'(0));
    tick();
    rst_n = 1'b1;
    chk("post_rst_rdy", 65'(in_ready), 65'(1));

    // Single op
    single_op("single");

    // Fill with back-pressure
    got.delete(); exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(64'(i), 64'(i));
    chk("fill_lvl3", 65'(level), 65'(3));
    chk("fill_vld", 65'(out_valid), 65'(1));
    chk("fill_sum0", 65'(out_sum), 65'(0));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_lvl3", 65'(level), 65'(3));
      chk("stall_sum0", 65'(out_sum), 65'(0));
    end
    push(64'd4, 64'd4);
    chk("full_lvl4", 65'(level), 65'(4));
    chk("full_rdy0", 65'(in_ready), 65'(0));
    in_a = 64'd5; in_b = 64'd5; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("full_reject_lvl", 65'(level), 65'(4));
      chk("full_hold_sum", 65'(out_sum), 65'(0));
    end

    // Drain across the pointer wrap while pushing more pairs
    out_ready = 1'b1;
    for (int j = 5; j <= 12; j++) push(64'(j), 64'(j));
    wait_idle();
    chk("drain_count", 65'(got.size()), 65'(exp_q.size()));
    chk("drain_0", got.size() > 0 ? got[0] : 65'h1_dead, 65'd0);
    chk("drain_1", got.size() > 1 ? got[1] : 65'h1_dead, 65'd2);
    chk("drain_2", got.size() > 2 ? got[2] : 65'h1_dead, 65'd4);
    chk("drain_3", got.size() > 3 ? got[3] : 65'h1_dead, 65'd6);
    chk("drain_4", got.size() > 4 ? got[4] : 65'h1_dead, 65'd8);
    chk("drain_5", got.size() > 5 ? got[5] : 65'h1_dead, 65'd10);
    for (int k = 0; k < exp_q.size() && k < got.size(); k++)
      chk("drain_order", got[k], exp_q[k]);

    // Signed overflow cases
    push(64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    tick();
    chk("ovf_sum", 65'(out_sum), 65'(64'h8000_0000_0000_0000));
    chk("ovf_cout", 65'(out_cout), 65'(0));
`ifdef ADDER_OVF_FLAG_EN
    chk("ovf_flag", 65'(out_ovf), 65'(1));
`endif
    wait_idle();
    push(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    tick();
    chk("negovf_sum", 65'(out_sum), 65'(0));
    chk("negovf_cout", 65'(out_cout), 65'(1));
`ifdef ADDER_OVF_FLAG_EN
    chk("negovf_flag", 65'(out_ovf), 65'(1));
`endif
    wait_idle();

    // Flush with a simultaneous push
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(64'(i + 20), 64'(i));
    chk("pre_flush_lvl", 65'(level), 65'(3));
    chk("pre_flush_vld", 65'(out_valid), 65'(1));
    in_a = 64'hDEAD; in_b = 64'd1; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_lvl", 65'(level), 65'(0));
    chk("flush_vld", 65'(out_valid), 65'(0));
    chk("flush_rdy", 65'(in_ready), 65'(1));
    got.delete();
    out_ready = 1'b1;
    push(64'd100, 64'd200);
    wait_idle();
    chk("post_flush_cnt", 65'(got.size()), 65'(1));
    chk("post_flush_sum", got.size() > 0 ? got[0] : 65'h1_dead, 65'd300);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(64'(i + 7), 64'(i + 1));
    chk("pre_rst_lvl", 65'(level), 65'(2));
    chk("pre_rst_vld", 65'(out_valid), 65'(1));
    chk("pre_rst_sum", 65'(out_sum), 65'(8));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 65'(out_valid), 65'(0));
    chk("arst_lvl", 65'(level), 65'(0));
    chk("arst_rdy", 65'(in_ready), 65'(1));
    chk("arst_sum", 65'(out_sum), 65'(0));
    chk("arst_cout", 65'(out_cout), 65'(0));
`ifdef ADDER_OVF_FLAG_EN
    chk("arst_ovf", 65'(out_ovf), 65'(0));
`endif
    tick();
    rst_n = 1'b1;
    single_op("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
